// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: result width, flag bit positions and beat types.
package cpu_pkg;

    localparam int DATA_W = 16;

    localparam int FLAG_COUT = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_NO   = 1;
    localparam int FLAG_ZO   = 0;

    typedef logic [3:0] flags_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        flags_t            flags;
    } result_beat_t;

endpackage

// File: rtl/result_fifo_mem.sv
// result_fifo_mem: DEPTH x WIDTH register array for the result FIFO.
// Synchronous write, combinational read; storage is deliberately not reset.
module result_fifo_mem #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the pushed beat into its slot; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_result_fifo.sv
// cpu_result_fifo: buffers ALU result + flags from a non-stallable CPU and drains
// them over a valid/ready handshake. Beats offered while full are dropped and
// counted in a saturating counter.
// Optional feature macro: RESULT_FIFO_STICKY_EN adds clr_sticky/sticky_flags,
// an OR-accumulation of the flags of every accepted beat.
module cpu_result_fifo #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_result,
    input  logic                       in_cout,
    input  logic                       in_overflow,
    input  logic                       in_no,
    input  logic                       in_zo,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     level,
`ifdef RESULT_FIFO_STICKY_EN
    input  logic                       clr_sticky,
    output logic [3:0]                 sticky_flags,
`endif
    output logic [CNT_W-1:0]           drop_cnt
);

    import cpu_pkg::*;

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int MEM_W = DATA_W + $bits(flags_t);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Saturating increment for the drop counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;
    flags_t           push_flags;
    logic [MEM_W-1:0] head;

    always_comb begin
        push_flags            = '0;
        push_flags[FLAG_COUT] = in_cout;
        push_flags[FLAG_OVF]  = in_overflow;
        push_flags[FLAG_NO]   = in_no;
        push_flags[FLAG_ZO]   = in_zo;
    end

    // Handshake status comes straight from the occupancy register, so in_ready
    // has no combinational dependence on out_ready.
    assign in_ready  = (level != FULL_LVL);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign drop      = in_valid & ~in_ready;

    result_fifo_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({in_result, push_flags}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Head entry is presented only when valid; zero while empty.
    assign out_result = out_valid ? head[MEM_W-1:4] : '0;
    assign out_flags  = out_valid ? head[3:0]       : '0;

    // Pointers wrap naturally (DEPTH is a power of two); level tracked separately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Count beats lost because the FIFO was full, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

`ifdef RESULT_FIFO_STICKY_EN
    // Accumulate flags of accepted beats; a clear overrides a same-cycle push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_flags <= '0;
        end else if (clr_sticky) begin
            sticky_flags <= '0;
        end else if (push) begin
            sticky_flags <= sticky_flags | push_flags;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_result_fifo.sv
// Directed testbench for cpu_result_fifo (DATA_W=16, DEPTH=8, CNT_W=8).
// Sticky-flag checks are compiled in when RESULT_FIFO_STICKY_EN is defined.
module tb_cpu_result_fifo;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_result;
    logic        in_cout;
    logic        in_overflow;
    logic        in_no;
    logic        in_zo;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;
`ifdef RESULT_FIFO_STICKY_EN
    logic        clr_sticky;
    logic [3:0]  sticky_flags;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cpu_result_fifo #(
        .DATA_W (16),
        .DEPTH  (8),
        .CNT_W  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_cout      (in_cout),
        .in_overflow  (in_overflow),
        .in_no        (in_no),
        .in_zo        (in_zo),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .level        (level),
`ifdef RESULT_FIFO_STICKY_EN
        .clr_sticky   (clr_sticky),
        .sticky_flags (sticky_flags),
`endif
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] f, input logic rdy);
        in_valid    = v;
        in_result   = d;
        in_cout     = f[3];
        in_overflow = f[2];
        in_no       = f[1];
        in_zo       = f[0];
        out_ready   = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        reset = 1'b0;
        #3;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
`ifdef RESULT_FIFO_STICKY_EN
        clr_sticky = 1'b0;
`endif
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        reset = 1'b0;
        #3;
        // Reset state
        check("rst_level",     32'(level),      32'd0);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_drop_cnt",  32'(drop_cnt),   32'd0);
        check("rst_out_res",   32'(out_result), 32'd0);
        check("rst_out_flags", 32'(out_flags),  32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Empty: out_ready ignored
        drive(1'b0, 16'h0, 4'h0, 1'b1);
        tick();
        check("empty_pop_level", 32'(level), 32'd0);

        // Single push into empty, consumer not ready
        drive(1'b1, 16'h1234, 4'b0001, 1'b0);
        check("push_no_bypass", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("push_out_valid", 32'(out_valid),  32'd1);
        check("push_out_res",   32'(out_result), 32'h1234);
        check("push_out_flags", 32'(out_flags),  32'h1);
        tick();
        tick();
        check("hold_out_res",   32'(out_result), 32'h1234);
        check("hold_out_flags", 32'(out_flags),  32'h1);
        check("hold_level",     32'(level),      32'd1);

        // Ten pushes into an empty FIFO with no consumer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 4'(i), 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("full_level",    32'(level),    32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_drop_cnt", 32'(drop_cnt), 32'd2);

        // Full with in_valid and out_ready together: pop proceeds, beat dropped
        check("fullpop_head", 32'(out_result), 32'h0100);
        drive(1'b1, 16'hDEAD, 4'hF, 1'b1);
        tick();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("fullpop_level",    32'(level),    32'd7);
        check("fullpop_drop_cnt", 32'(drop_cnt), 32'd3);
        check("fullpop_in_ready", 32'(in_ready), 32'd1);

        // Drain remaining entries 1..7 in order
        for (int i = 1; i < 8; i++) begin
            check($sformatf("drain_res%0d", i),   32'(out_result), 32'h0100 + i);
            check($sformatf("drain_flags%0d", i), 32'(out_flags),  32'(i));
            drive(1'b0, 16'h0, 4'h0, 1'b1);
            tick();
        end
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("drained_level", 32'(level),     32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Async reset mid-stream with level 5
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0200 + 16'(i), 4'h2, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("mid_level_pre", 32'(level), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check("mid_level",     32'(level),     32'd0);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_drop_cnt",  32'(drop_cnt),  32'd0);
        check("mid_in_ready",  32'(in_ready),  32'd1);
        tick();
        reset = 1'b1;
        tick();
        drive(1'b1, 16'hBEEF, 4'b0100, 1'b0);
        tick();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("post_rst_res",   32'(out_result), 32'hBEEF);
        check("post_rst_flags", 32'(out_flags),  32'h4);
        check("post_rst_level", 32'(level),      32'd1);

        // Level 3, simultaneous push+pop for 20 cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0A00 + 16'(i), 4'(i), 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            check($sformatf("pp_res%0d", i), 32'(out_result), 32'h0A00 + i);
            drive(1'b1, 16'h0A00 + 16'(i + 3), 4'(i + 3), 1'b1);
            tick();
            check($sformatf("pp_level%0d", i), 32'(level), 32'd3);
        end
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("pp_flags_end", 32'(out_flags), 32'(4'(20)));

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 8 + 260; i++) begin
            drive(1'b1, 16'(i), 4'h0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("sat_drop_cnt", 32'(drop_cnt),   32'd255);
        check("sat_head",     32'(out_result), 32'd0);

`ifdef RESULT_FIFO_STICKY_EN
        // Sticky accumulation and clear-wins
        do_reset();
        check("sticky_rst", 32'(sticky_flags), 32'h0);
        drive(1'b1, 16'h1, 4'b1000, 1'b0);
        tick();
        drive(1'b1, 16'h2, 4'b0010, 1'b0);
        tick();
        check("sticky_or", 32'(sticky_flags), 32'hA);
        clr_sticky = 1'b1;
        drive(1'b1, 16'h3, 4'b0001, 1'b0);
        tick();
        clr_sticky = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("sticky_clr", 32'(sticky_flags), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
